// File: rtl/wormhole_input_unit.sv
// Wormhole input channel: flit FIFO, head latch for routing, allocation handshake, packet streaming.
// Head written at edge N gives req_o in cycle N+2 and data on data_o one cycle after grant; link is backpressured by rdy_o (FIFO not full).
module wormhole_input_unit #(
    parameter int FLIT_DATA_W    = 8,
    parameter int FLIT_ID_W      = 2,
    parameter int HOP_CNT_W      = 4,
    parameter int BUFFER_DEPTH_W = 2,
    localparam int FLIT_W        = FLIT_ID_W + FLIT_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [FLIT_W-1:0] data_i,
    input  logic              data_vld_i,
    output logic              rdy_o,
    output logic [FLIT_W-1:0] header_o,
    output logic              req_o,
    input  logic              grant_i,
    output logic [FLIT_W-1:0] data_o,
    output logic              data_vld_o,
    input  logic              out_rdy_i,
    output logic              err_o
);
    localparam int DEPTH = 1 << BUFFER_DEPTH_W;
    localparam logic [BUFFER_DEPTH_W:0] DEPTH_CNT = (BUFFER_DEPTH_W + 1)'(DEPTH);

    localparam logic [FLIT_ID_W-1:0] ID_HEAD   = FLIT_ID_W'(2'b10);
    localparam logic [FLIT_ID_W-1:0] ID_TAIL   = FLIT_ID_W'(2'b11);
    localparam logic [FLIT_ID_W-1:0] ID_SINGLE = FLIT_ID_W'(2'b01);

    typedef enum logic [1:0] {IDLE, WAIT_ALLOC, ACTIVE} state_t;

    logic [FLIT_W-1:0]         mem [DEPTH];
    logic [BUFFER_DEPTH_W-1:0] wr_ptr;
    logic [BUFFER_DEPTH_W-1:0] rd_ptr;
    logic [BUFFER_DEPTH_W:0]   count;
    logic                      empty;
    logic                      full;
    logic                      push;
    logic                      pop;
    logic                      pop_tx;
    logic                      pop_orphan;

    state_t                    state;
    logic                      first;
    logic [FLIT_W-1:0]         top;
    logic [FLIT_ID_W-1:0]      top_id;
    logic                      is_start;
    logic                      is_end;
    logic [HOP_CNT_W-1:0]      hop;
    logic [HOP_CNT_W-1:0]      hop_next;
    logic [FLIT_W-1:0]         tx_flit;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);
    assign rdy_o = !full;
    assign push  = data_vld_i && !full;

    assign top      = mem[rd_ptr];
    assign top_id   = top[FLIT_W-1 -: FLIT_ID_W];
    assign is_start = (top_id == ID_HEAD) || (top_id == ID_SINGLE);
    assign is_end   = (top_id == ID_TAIL) || (top_id == ID_SINGLE);

    assign pop_tx     = (state == ACTIVE) && !empty && out_rdy_i;
    assign pop_orphan = (state == IDLE) && !empty && !is_start;
    assign pop        = pop_tx || pop_orphan;

    // Only the packet's own opening flit gets its hop bumped; a stray HEAD mid-packet is plain payload.
    assign hop      = top[HOP_CNT_W-1:0];
    assign hop_next = (&hop) ? hop : hop + HOP_CNT_W'(1);
    assign tx_flit  = first ? {top[FLIT_W-1:HOP_CNT_W], hop_next} : top;

    assign data_vld_o = (state == ACTIVE) && !empty;
    assign data_o     = data_vld_o ? tx_flit : '0;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            header_o <= '0;
            req_o    <= 1'b0;
            err_o    <= 1'b0;
            first    <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        if (is_start) begin
                            header_o <= top;
                            req_o    <= 1'b1;
                            state    <= WAIT_ALLOC;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                WAIT_ALLOC: begin
                    if (grant_i) begin
                        first <= 1'b1;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (pop_tx) begin
                        first <= 1'b0;
                        if (is_end) begin
                            req_o <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    req_o <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wormhole_input_unit.sv
// Self-checking bench: scenario tasks with inline checks plus a scoreboard of expected crossbar flits.
module tb_wormhole_input_unit;
    localparam int FW = 10;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [FW-1:0] data_i;
    logic          data_vld_i;
    logic          rdy_o;
    logic [FW-1:0] header_o;
    logic          req_o;
    logic          grant_i;
    logic [FW-1:0] data_o;
    logic          data_vld_o;
    logic          out_rdy_i;
    logic          err_o;

    int            errors = 0;
    int            checks = 0;
    int            n_out  = 0;
    bit            done   = 1'b0;
    logic [FW-1:0] sb[$];

    wormhole_input_unit dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .data_i     (data_i),
        .data_vld_i (data_vld_i),
        .rdy_o      (rdy_o),
        .header_o   (header_o),
        .req_o      (req_o),
        .grant_i    (grant_i),
        .data_o     (data_o),
        .data_vld_o (data_vld_o),
        .out_rdy_i  (out_rdy_i),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [FW-1:0] f);
        data_i     = f;
        data_vld_i = 1'b1;
        tick();
        data_vld_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; data_i = '0; data_vld_i = 1'b0; grant_i = 1'b0; out_rdy_i = 1'b1;
        tick(); tick();
        checks++;
        if ({rdy_o, req_o, data_vld_o, err_o} !== 4'b1000 || data_o !== '0 || header_o !== '0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b req=%b vld=%b err=%b data=%h hdr=%h, want 1 0 0 0 000 000",
                     rdy_o, req_o, data_vld_o, err_o, data_o, header_o);
        end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic_packet();
        sb.push_back(10'b10_01_10_0100);
        sb.push_back(10'b00_1010_0101);
        sb.push_back(10'b11_0000_1111);
        data_i = 10'b10_01_10_0011; data_vld_i = 1'b1;
        tick();                                   // cycle 1
        checks++;
        if (req_o !== 1'b0) begin errors++; $display("FAIL basic_req_c1: got %b want 0", req_o); end
        data_i = 10'b00_1010_0101;
        tick();                                   // cycle 2
        checks++;
        if (req_o !== 1'b1 || header_o !== 10'b10_01_10_0011) begin
            errors++; $display("FAIL basic_req_c2: req=%b hdr=%b want 1 1001100011", req_o, header_o);
        end
        checks++;
        if (data_vld_o !== 1'b0 || data_o !== '0) begin
            errors++; $display("FAIL basic_idle_data: vld=%b data=%h want 0 000", data_vld_o, data_o);
        end
        data_i = 10'b11_0000_1111; grant_i = 1'b1;
        tick();                                   // cycle 3
        data_vld_i = 1'b0; grant_i = 1'b0;
        checks++;
        if (data_vld_o !== 1'b1 || data_o !== 10'b10_01_10_0100) begin
            errors++; $display("FAIL basic_head_c3: vld=%b data=%b want 1 1001100100", data_vld_o, data_o);
        end
        tick(); tick(); tick();                   // cycle 6
        checks++;
        if (req_o !== 1'b0 || data_vld_o !== 1'b0) begin
            errors++; $display("FAIL basic_end_c6: req=%b vld=%b want 0 0", req_o, data_vld_o);
        end
    endtask

    task automatic test_hop_saturation();
        sb.push_back(10'b01_11_00_1111);
        send(10'b01_11_00_1111);
        tick();
        checks++;
        if (req_o !== 1'b1 || header_o[3:0] !== 4'hF) begin
            errors++; $display("FAIL hop_header: req=%b hdr_hop=%h want 1 f", req_o, header_o[3:0]);
        end
        grant_i = 1'b1;
        tick();
        grant_i = 1'b0;
        checks++;
        if (data_vld_o !== 1'b1 || data_o !== 10'b01_11_00_1111) begin
            errors++; $display("FAIL hop_sat_data: vld=%b data=%b want 1 0111001111", data_vld_o, data_o);
        end
        tick();
        checks++;
        if (req_o !== 1'b0 || data_vld_o !== 1'b0) begin
            errors++; $display("FAIL hop_idle_after: req=%b vld=%b want 0 0", req_o, data_vld_o);
        end
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] f [5];
        int            start_out;
        f[0] = 10'b10_00_11_0111; f[1] = 10'b00_0000_0001; f[2] = 10'b00_0000_0010;
        f[3] = 10'b11_0000_0011;  f[4] = 10'b00_1111_1111;
        sb.push_back(10'b10_00_11_1000);
        sb.push_back(f[1]); sb.push_back(f[2]); sb.push_back(f[3]);
        start_out = n_out;
        for (int i = 0; i < 5; i++) begin
            data_i = f[i]; data_vld_i = 1'b1;
            checks++;
            if (rdy_o !== (i < 4)) begin
                errors++; $display("FAIL full_rdy_w%0d: got %b want %b", i, rdy_o, (i < 4));
            end
            tick();
        end
        data_vld_i = 1'b0;
        grant_i = 1'b1;
        tick();
        grant_i = 1'b0;
        for (int i = 0; i < 12; i++) begin
            out_rdy_i = (i % 2 == 0);
            if (i == 0) begin
                checks++;
                if (rdy_o !== 1'b0) begin errors++; $display("FAIL full_pop_rdy: got %b want 0", rdy_o); end
            end
            if (i == 1) begin
                checks++;
                if (rdy_o !== 1'b1) begin errors++; $display("FAIL full_rdy_rise: got %b want 1", rdy_o); end
            end
            if (i > 7) begin
                checks++;
                if (err_o !== 1'b0 || req_o !== 1'b0) begin
                    errors++; $display("FAIL full_ignored_write: err=%b req=%b want 0 0", err_o, req_o);
                end
            end
            tick();
        end
        out_rdy_i = 1'b1;
        checks++;
        if (n_out - start_out !== 4) begin
            errors++; $display("FAIL full_flit_count: got %0d want 4", n_out - start_out);
        end
    endtask

    task automatic test_orphan();
        logic exp_err [4];
        exp_err[0] = 1'b0; exp_err[1] = 1'b1; exp_err[2] = 1'b1; exp_err[3] = 1'b0;
        data_i = 10'b00_0011_0011; data_vld_i = 1'b1;
        tick();
        data_i = 10'b11_0011_0011;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (err_o !== exp_err[c] || req_o !== 1'b0 || data_vld_o !== 1'b0 || data_o !== '0) begin
                errors++;
                $display("FAIL orphan_c%0d: err=%b req=%b vld=%b data=%h want %b 0 0 000",
                         c + 1, err_o, req_o, data_vld_o, data_o, exp_err[c]);
            end
            tick();
            data_vld_i = 1'b0;
        end
        checks++;
        if (rdy_o !== 1'b1) begin errors++; $display("FAIL orphan_rdy: got %b want 1", rdy_o); end
    endtask

    task automatic test_back_to_back();
        logic       exp_req [4];
        logic       exp_vld [4];
        exp_req[0] = 1'b1; exp_req[1] = 1'b0; exp_req[2] = 1'b1; exp_req[3] = 1'b1;
        exp_vld[0] = 1'b1; exp_vld[1] = 1'b0; exp_vld[2] = 1'b0; exp_vld[3] = 1'b1;
        sb.push_back(10'b01_01_01_0001);
        sb.push_back(10'b01_10_10_1111);
        grant_i = 1'b1;
        data_i = 10'b01_01_01_0000; data_vld_i = 1'b1;
        tick();
        data_i = 10'b01_10_10_1110;
        tick();
        data_vld_i = 1'b0;
        tick();                                   // cycle 3: first single on the crossbar
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (req_o !== exp_req[c] || data_vld_o !== exp_vld[c]) begin
                errors++;
                $display("FAIL b2b_c%0d: req=%b vld=%b want %b %b", c + 3, req_o, data_vld_o, exp_req[c], exp_vld[c]);
            end
            tick();
        end
        grant_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_packet();
        sb.push_back(10'b10_11_11_0010);
        sb.push_back(10'b00_0101_0101);
        data_i = 10'b10_11_11_0001; data_vld_i = 1'b1;
        tick();
        data_i = 10'b00_0101_0101;
        tick();
        data_vld_i = 1'b0; grant_i = 1'b1;
        tick();
        grant_i = 1'b0;
        tick(); tick();                           // head and body gone, still ACTIVE
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({rdy_o, req_o, data_vld_o, err_o} !== 4'b1000 || data_o !== '0 || header_o !== '0) begin
            errors++;
            $display("FAIL async_reset: rdy=%b req=%b vld=%b err=%b data=%h hdr=%h, want 1 0 0 0 000 000",
                     rdy_o, req_o, data_vld_o, err_o, data_o, header_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
        sb.push_back(10'b10_00_01_0110);
        sb.push_back(10'b11_1000_1000);
        send(10'b00_0110_0110);
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL rst_orphan_c1: err=%b want 0", err_o); end
        send(10'b11_0111_0111);
        checks++;
        if (err_o !== 1'b1) begin errors++; $display("FAIL rst_orphan_c2: err=%b want 1", err_o); end
        send(10'b10_00_01_0101);
        checks++;
        if (err_o !== 1'b1 || req_o !== 1'b0) begin
            errors++; $display("FAIL rst_orphan_c3: err=%b req=%b want 1 0", err_o, req_o);
        end
        tick();
        checks++;
        if (err_o !== 1'b0 || req_o !== 1'b1 || header_o !== 10'b10_00_01_0101) begin
            errors++; $display("FAIL rst_new_head: err=%b req=%b hdr=%b want 0 1 1000010101", err_o, req_o, header_o);
        end
        grant_i = 1'b1;
        tick();
        grant_i = 1'b0;
        send(10'b11_1000_1000);
        tick(); tick();
        checks++;
        if (req_o !== 1'b0) begin errors++; $display("FAIL rst_new_pkt_end: req=%b want 0", req_o); end
    endtask

    initial begin
        fork
            begin
                while (!done) begin
                    @(negedge clk_i);
                    if (rst_ni === 1'b1 && data_vld_o === 1'b1 && out_rdy_i === 1'b1) begin
                        logic [FW-1:0] exp;
                        n_out++;
                        checks++;
                        if (sb.size() == 0) begin
                            errors++; $display("FAIL sb_unexpected: got %b want no flit", data_o);
                        end else begin
                            exp = sb.pop_front();
                            if (data_o !== exp) begin
                                errors++; $display("FAIL sb_flit: got %b want %b", data_o, exp);
                            end
                        end
                    end
                end
            end
            begin
                test_reset();
                test_basic_packet();
                test_hop_saturation();
                test_backpressure();
                test_orphan();
                test_back_to_back();
                test_reset_mid_packet();
                tick(); tick();
                checks++;
                if (sb.size() != 0) begin
                    errors++; $display("FAIL sb_drain: got %0d pending want 0", sb.size());
                end
                done = 1'b1;
            end
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wormhole_input_unit.md
# wormhole_input_unit

Per-input-channel front end of the 2D-mesh wormhole node. It buffers incoming flits in a FIFO and detects packet boundaries from the flit ID. It latches the head flit for the XY router, requests an output channel from the allocator, and then streams the whole packet to the crossbar until the tail flit leaves. One instance sits on each of the node's IN_N input channels, between the link and the crossbar.

## Interface
- FLIT_DATA_W, 8: flit payload width; head payload is {row_addr, col_addr, hop_cnt}, MSB first.
- FLIT_ID_W, 2: flit type field width, at the top of the flit. FLIT_W = FLIT_ID_W + FLIT_DATA_W.
- HOP_CNT_W, 4: hop count field width, at payload bits [HOP_CNT_W-1:0].
- BUFFER_DEPTH_W, 2: FIFO depth is 2^BUFFER_DEPTH_W flits.

Ports:
- clk_i, in, 1: single clock.
- rst_ni, in, 1: asynchronous, active-low reset.
- data_i, in, FLIT_W: incoming flit.
- data_vld_i, in, 1: flit write strobe from the link.
- rdy_o, out, 1: FIFO not full (link backpressure).
- header_o, out, FLIT_W: latched head flit for the router and allocator, unmodified.
- req_o, out, 1: output-channel allocation request.
- grant_i, in, 1: allocation grant from the allocator.
- data_o, out, FLIT_W: flit to the crossbar.
- data_vld_o, out, 1: data_o valid.
- out_rdy_i, in, 1: downstream channel ready.
- err_o, out, 1: one-cycle pulse when an orphan flit is dropped.

## Operation
- Flit IDs:
  - 2'b10 HEAD
  - 2'b00 BODY
  - 2'b11 TAIL
  - 2'b01 SINGLE (head and tail in one flit)
- FIFO:
  - Write when data_vld_i && rdy_o. A write while full is ignored and the count is unchanged.
  - rdy_o = !full. It is derived from the count only and never from the same-cycle pop.
  - Count width is BUFFER_DEPTH_W+1. Pointers wrap modulo depth.
  - Simultaneous push and pop leaves the count unchanged.
- State machine: IDLE, WAIT_ALLOC, ACTIVE.
  - IDLE, FIFO top is HEAD or SINGLE: latch the top flit into header_o and go to WAIT_ALLOC. The flit stays in the FIFO.
  - IDLE, FIFO top is BODY or TAIL (orphan): pop it, pulse err_o for one cycle, stay in IDLE.
  - WAIT_ALLOC: req_o=1. On grant_i=1, go to ACTIVE next cycle. grant_i is ignored in all other states.
  - ACTIVE:
    - req_o stays 1.
    - data_o = FIFO top and data_vld_o = !empty.
    - Pop when data_vld_o && out_rdy_i.
    - Popping TAIL or SINGLE returns the unit to IDLE next cycle and drops req_o.
- Hop count:
  - On the transmitted HEAD/SINGLE flit, the hop field of data_o is incremented, saturating at all-ones.
  - All other bits pass unchanged.
  - header_o carries the original value.
- data_o is driven to 0 whenever data_vld_o=0.
- A HEAD arriving mid-packet in ACTIVE is forwarded as an ordinary flit. The packet still ends only on TAIL or SINGLE.

## Timing
- Reset values: rdy_o=1, req_o=0, data_vld_o=0, data_o=0, header_o=0, err_o=0. FIFO empty, state IDLE.
- Reset mid-packet drops all buffered flits. Later BODY/TAIL flits of that packet are dropped as orphans with err_o.
- A flit written at edge N is visible at the FIFO top in cycle N+1.
- Head path:
  - Head written at edge N: header_o updated and req_o=1 from cycle N+2.
  - If grant_i=1 in N+2, the head flit appears on data_o with data_vld_o=1 in cycle N+3.
- Sustained throughput is 1 flit/cycle in ACTIVE while the FIFO is non-empty and out_rdy_i=1.
- Back-to-back packets: tail popped at edge T gives IDLE in T+1 and WAIT_ALLOC in T+2. There is a minimum 2-cycle bubble between packets.
- Full FIFO with a pop in the same cycle: rdy_o stays 0 that cycle and rises the next cycle.
- An orphan pop takes 1 cycle per flit. err_o is registered and aligned with the cycle after the pop.

## Test plan
- Reset/idle:
  - Stimulus: assert rst_ni=0 mid-run.
  - Required response: all outputs take their reset values immediately and asynchronously, and rdy_o=1.
- Basic packet:
  - Stimulus: HEAD 10_01_10_0011 at cycle 0, BODY, TAIL; grant_i=1 in cycle 2; out_rdy_i=1.
  - Required response: req_o=1 from cycle 2; data_o = 10_01_10_0100 in cycle 3, then BODY, then TAIL; req_o=0 in cycle 6.
- Hop saturation:
  - Stimulus: SINGLE flit with hop=4'hF.
  - Required response: transmitted hop=4'hF, header_o hop=4'hF, unit back in IDLE after one flit.
- Backpressure/full:
  - Stimulus: 5 writes with no grant, depth 4.
  - Required response: rdy_o=0 after the 4th write and the 5th write is ignored. After grant with out_rdy_i toggling 1/0, exactly 4 flits come out in order.
- Orphan:
  - Stimulus: BODY then TAIL written in IDLE.
  - Required response: two err_o pulses, no req_o, FIFO empty afterwards.
- Reset mid-packet:
  - Stimulus: reset after HEAD and one BODY are sent; then send BODY, TAIL, new HEAD.
  - Required response: two err_o pulses, then a normal request for the new HEAD.
